fib_lookup_scheduler: RTL and testbench

- Sits in front of the FIB level pipeline and shares it among `NUM_REQ` requesters (faces).
- Arbitrates round-robin, launching at most one name per cycle into stage 0.
- Tags each launch with the requester ID in a latency-matched shadow pipeline, then routes each retiring result back to the originating requester.
- Provides enable/drain sequencing so the pipeline can be quiesced before level memories are reloaded.

---
 rtl/fib_lookup_scheduler.sv | 118 +++++++++++
 tb/tb_fib_lookup_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_lookup_scheduler.sv
// fib_lookup_scheduler: round-robin front end sharing the FIB level pipeline among requesters
module fib_lookup_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WORD_SIZE = 16,
  parameter int MAX_NAME_LENGTH = 16,
  parameter int POINTER_SIZE = 16,
  parameter int PIPE_LATENCY = 100,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                                         clk_in,
  input  logic                                         rst_n_in,
  input  logic                                         enable_in,
  input  logic                                         drain_in,
  input  logic [NUM_REQ-1:0]                           req_valid_in,
  input  logic [NUM_REQ*MAX_NAME_LENGTH*WORD_SIZE-1:0] req_name_in,
  output logic [NUM_REQ-1:0]                           req_ready_out,
  output logic                                         pipe_valid_out,
  output logic [MAX_NAME_LENGTH*WORD_SIZE-1:0]         pipe_name_out,
  input  logic                                         pipe_result_valid_in,
  input  logic                                         pipe_match_in,
  input  logic                                         pipe_no_child_in,
  input  logic [POINTER_SIZE-1:0]                      pipe_pointer_in,
  output logic [NUM_REQ-1:0]                           rsp_valid_out,
  output logic                                         rsp_match_out,
  output logic                                         rsp_no_child_out,
  output logic [POINTER_SIZE-1:0]                      rsp_pointer_out,
  output logic [$clog2(PIPE_LATENCY+1)-1:0]            inflight_out,
  output logic                                         busy_out,
  output logic                                         err_out
);
  localparam int NW = MAX_NAME_LENGTH * WORD_SIZE;
  localparam int CW = $clog2(PIPE_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [ID_W-1:0] last, grantId, launchId, idx;
  logic found, transfer, tailValid, tailHit;
  logic [PIPE_LATENCY-1:0] tagValid;
  logic [ID_W-1:0] tagId [PIPE_LATENCY];
  assign transfer = (state == RUN) && enable_in && !drain_in && found;
  assign req_ready_out = transfer ? NUM_REQ'(1) << grantId : '0;
  assign tailValid = tagValid[PIPE_LATENCY-1];
  assign tailHit = tailValid && pipe_result_valid_in;
  assign busy_out = (state != IDLE) || (inflight_out != '0);
  // first valid requester searching from the one after the last grant, wrapping
  always_comb begin
    grantId = last;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last) + k) % NUM_REQ);
      if (!found && req_valid_in[idx]) begin
        found = 1'b1;
        grantId = idx;
      end
    end
  end
  // enable/drain sequencing and round-robin pointer; drain waits for launches still in the launch register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      last <= ID_W'(NUM_REQ - 1);
    end else begin
      if (transfer) last <= grantId;
      state <= (state == IDLE)  ? (drain_in ? DRAIN : enable_in ? RUN : IDLE) :
               (state == RUN)   ? ((drain_in || !enable_in) ? DRAIN : RUN) :
               (state == DRAIN) ? ((!drain_in && inflight_out == '0 && !pipe_valid_out) ? IDLE : DRAIN) :
               IDLE;
    end
  end
  // launch register feeding stage 0; the name holds between launches
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pipe_valid_out <= 1'b0;
      pipe_name_out <= '0;
      launchId <= '0;
    end else begin
      pipe_valid_out <= transfer;
      if (transfer) begin
        pipe_name_out <= req_name_in[grantId*NW +: NW];
        launchId <= grantId;
      end
    end
  end
  // requester tags travel alongside the level pipeline and line up with its result at the tail
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tagValid <= '0;
      for (int i = 0; i < PIPE_LATENCY; i++) tagId[i] <= '0;
      inflight_out <= '0;
    end else begin
      tagValid[0] <= pipe_valid_out;
      tagId[0] <= launchId;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        tagValid[i] <= tagValid[i-1];
        tagId[i] <= tagId[i-1];
      end
      inflight_out <= inflight_out + CW'(pipe_valid_out) - CW'(tailValid);
    end
  end
  // route retiring results to their requester; a tag/result disagreement is latched until reset
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rsp_valid_out <= '0;
      rsp_match_out <= 1'b0;
      rsp_no_child_out <= 1'b0;
      rsp_pointer_out <= '0;
      err_out <= 1'b0;
    end else begin
      rsp_valid_out <= tailHit ? NUM_REQ'(1) << tagId[PIPE_LATENCY-1] : '0;
      if (tailHit) begin
        rsp_match_out <= pipe_match_in;
        rsp_no_child_out <= pipe_no_child_in;
        rsp_pointer_out <= pipe_pointer_in;
      end
      if (tailValid != pipe_result_valid_in) err_out <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fib_lookup_scheduler.sv
// tb_fib_lookup_scheduler: scoreboard and vector bench for the FIB lookup scheduler
module tb_fib_lookup_scheduler;
  localparam int N = 4, WS = 16, ML = 16, PS = 16, LA = 10, LB = 3, NW = ML * WS;
  typedef struct {logic [N-1:0] oh; logic [PS-1:0] ptr; logic m; logic n; int due;} exp_t;
  typedef struct {logic [N-1:0] v; logic [N-1:0] rdy;} vec_t;
  logic clk = 1'b0, rstN = 1'b0;
  int total = 0, bad = 0, cyc = 0;
  exp_t sbq[$];
  vec_t tbl[10];
  logic enA = 0, drA = 0, injV = 0, enB = 0;
  logic [N-1:0] rvA = '0, rvB = '0, rdyA, rdyB, rspA, rspB;
  logic [N*NW-1:0] rnA = '0, rnB = '0;
  logic pvA, pvB, prvA, prvB, pmA, pmB, pncA, pncB, rmA, rmB, rncA, rncB, busyA, busyB, errA, errB;
  logic [NW-1:0] pnA, pnB;
  logic [PS-1:0] ppA, ppB, rpA, rpB;
  logic [3:0] infA;
  logic [1:0] infB;
  logic [LA-1:0] eVA;
  logic [LB-1:0] eVB;
  logic [PS+1:0] eDA [LA];
  logic [PS+1:0] eDB [LB];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // behavioural level pipeline: result returns as {match, no_child, pointer} derived from the name
  function automatic logic [PS+1:0] res(input logic [NW-1:0] nm);
    return {~nm[16], nm[17], nm[15:0] + 16'h00AA};
  endfunction
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      eVA <= '0;
      for (int i = 0; i < LA; i++) eDA[i] <= '0;
    end else begin
      eVA <= {eVA[LA-2:0], pvA};
      eDA[0] <= res(pnA);
      for (int i = 1; i < LA; i++) eDA[i] <= eDA[i-1];
    end
  end
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      eVB <= '0;
      for (int i = 0; i < LB; i++) eDB[i] <= '0;
    end else begin
      eVB <= {eVB[LB-2:0], pvB};
      eDB[0] <= res(pnB);
      for (int i = 1; i < LB; i++) eDB[i] <= eDB[i-1];
    end
  end
  assign prvA = eVA[LA-1] | injV;
  assign {pmA, pncA, ppA} = eDA[LA-1];
  assign prvB = eVB[LB-1];
  assign {pmB, pncB, ppB} = eDB[LB-1];
  fib_lookup_scheduler #(.NUM_REQ(N), .WORD_SIZE(WS), .MAX_NAME_LENGTH(ML), .POINTER_SIZE(PS), .PIPE_LATENCY(LA)) dutA (
    .clk_in(clk), .rst_n_in(rstN), .enable_in(enA), .drain_in(drA), .req_valid_in(rvA), .req_name_in(rnA),
    .req_ready_out(rdyA), .pipe_valid_out(pvA), .pipe_name_out(pnA), .pipe_result_valid_in(prvA),
    .pipe_match_in(pmA), .pipe_no_child_in(pncA), .pipe_pointer_in(ppA), .rsp_valid_out(rspA),
    .rsp_match_out(rmA), .rsp_no_child_out(rncA), .rsp_pointer_out(rpA), .inflight_out(infA),
    .busy_out(busyA), .err_out(errA));
  fib_lookup_scheduler #(.NUM_REQ(N), .WORD_SIZE(WS), .MAX_NAME_LENGTH(ML), .POINTER_SIZE(PS), .PIPE_LATENCY(LB)) dutB (
    .clk_in(clk), .rst_n_in(rstN), .enable_in(enB), .drain_in(1'b0), .req_valid_in(rvB), .req_name_in(rnB),
    .req_ready_out(rdyB), .pipe_valid_out(pvB), .pipe_name_out(pnB), .pipe_result_valid_in(prvB),
    .pipe_match_in(pmB), .pipe_no_child_in(pncB), .pipe_pointer_in(ppB), .rsp_valid_out(rspB),
    .rsp_match_out(rmB), .rsp_no_child_out(rncB), .rsp_pointer_out(rpB), .inflight_out(infB),
    .busy_out(busyB), .err_out(errB));
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  // pop and compare responses, then record any transfer about to happen on the next edge
  task automatic monitor();
    exp_t e;
    if (rspA != '0) begin
      if (sbq.size() == 0) chk("rsp_unexpected", rspA, 0);
      else begin
        e = sbq.pop_front();
        chk("rsp_id", rspA, e.oh);
        chk("rsp_ptr", rpA, e.ptr);
        chk("rsp_flags", {rmA, rncA}, {e.m, e.n});
        chk("rsp_latency", cyc, e.due);
      end
    end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
      chk("rsp_missing", cyc, sbq[0].due);
      void'(sbq.pop_front());
    end
    for (int i = 0; i < N; i++) begin
      if (rvA[i] && rdyA[i]) begin
        e.oh = rdyA;
        {e.m, e.n, e.ptr} = res(rnA[i*NW +: NW]);
        e.due = cyc + LA + 2;
        sbq.push_back(e);
      end
    end
  endtask
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask
  task automatic randNames();
    for (int i = 0; i < N * NW / 32; i++) rnA[i*32 +: 32] = $urandom;
  endtask
  task automatic waitEmpty(input string nm, input int bound);
    int n = 0;
    while ((sbq.size() != 0 || infA != '0) && n < bound) begin
      tick();
      n++;
    end
    chk(nm, n < bound, 1);
  endtask
  initial begin
    int n;
    logic seen;
    logic [PS+1:0] rb;
    tbl = '{'{4'b1111, 4'b1000}, '{4'b1111, 4'b0001}, '{4'b1010, 4'b0010}, '{4'b1010, 4'b1000},
            '{4'b0101, 4'b0001}, '{4'b0101, 4'b0100}, '{4'b0001, 4'b0001}, '{4'b0000, 4'b0000},
            '{4'b0000, 4'b0000}, '{4'b1000, 4'b1000}};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", rdyA, 0);
    chk("rst_pvalid", pvA, 0);
    chk("rst_rsp", rspA, 0);
    chk("rst_inflight", infA, 0);
    chk("rst_busy", busyA, 0);
    chk("rst_err", errA, 0);
    rstN = 1;
    enA = 1;
    tick();
    for (int w = 0; w < ML; w++) rnA[2*NW + w*WS +: WS] = WS'(w + 1);
    rvA = 4'b0100;
    #2 chk("t1_ready", rdyA, 4'b0100);
    tick();
    rvA = '0;
    chk("t1_pvalid", pvA, 1);
    chk("t1_name", pnA == rnA[2*NW +: NW], 1);
    waitEmpty("t1_wait", LA + 10);
    chk("t1_ptr", rpA, 16'h00AB);
    chk("t1_match", rmA, 1);
    for (int i = 0; i < 10; i++) begin
      randNames();
      rvA = tbl[i].v;
      #2 chk($sformatf("arb_vec%0d", i), rdyA, tbl[i].rdy);
      tick();
    end
    rvA = '0;
    waitEmpty("tbl_wait", 40);
    rvA = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      randNames();
      #2 chk($sformatf("t2_grant%0d", i), rdyA, 4'b0001 << (i % 4));
      tick();
    end
    rvA = '0;
    tick();
    chk("t2_inflight", infA, 8);
    waitEmpty("t2_wait", 40);
    rvA = 4'b1111;
    repeat (3) begin
      randNames();
      tick();
    end
    drA = 1;
    #2 chk("t3_stop_now", rdyA, 0);
    tick();
    drA = 0;
    #2 chk("t3_stop_drain", rdyA, 0);
    chk("t3_busy", busyA, 1);
    rvA = '0;
    n = 0;
    while (busyA && n < 40) begin
      tick();
      n++;
    end
    chk("t3_idle_wait", n < 40, 1);
    chk("t3_sb_empty", sbq.size(), 0);
    chk("t3_inflight", infA, 0);
    enA = 0;
    n = 0;
    repeat (2) tick();
    while (busyA && n < 20) begin
      tick();
      n++;
    end
    chk("t4_idle_wait", n < 20, 1);
    injV = 1;
    tick();
    injV = 0;
    chk("t4_err_set", errA, 1);
    chk("t4_no_rsp", rspA, 0);
    repeat (3) tick();
    chk("t4_err_sticky", errA, 1);
    enA = 1;
    tick();
    rvA = 4'b1111;
    repeat (5) begin
      randNames();
      tick();
    end
    rvA = '0;
    tick();
    chk("t5_inflight_pre", infA, 5);
    rstN = 0;
    #1;
    chk("t5_rst_err", errA, 0);
    chk("t5_rst_inflight", infA, 0);
    chk("t5_rst_busy", busyA, 0);
    chk("t5_rst_pvalid", pvA, 0);
    chk("t5_rst_name", pnA == '0, 1);
    sbq.delete();
    repeat (2) tick();
    rstN = 1;
    seen = 0;
    repeat (LA + 4) begin
      tick();
      seen |= (rspA != '0);
    end
    chk("t5_no_rsp", seen, 0);
    chk("t5_err_clear", errA, 0);
    chk("t5_inflight_post", infA, 0);
    rvA = 4'b1111;
    #2 chk("t5_first_grant", rdyA, 4'b0001);
    tick();
    rvA = '0;
    waitEmpty("t5_wait", 40);
    enB = 1;
    tick();
    for (int i = 0; i < N * NW / 32; i++) rnB[i*32 +: 32] = $urandom;
    rb = res(rnB[NW +: NW]);
    rvB = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      #2 chk($sformatf("t6_ready%0d", i), rdyB, 4'b0010);
      if (i >= 5) begin
        chk($sformatf("t6_inflight%0d", i), infB, LB);
        chk($sformatf("t6_rsp%0d", i), rspB, 4'b0010);
        chk($sformatf("t6_ptr%0d", i), rpB, rb[PS-1:0]);
      end
      tick();
    end
    rvB = '0;
    enB = 0;
    chk("t6_err", errB, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
